// File: rtl/intra_net_pkg.sv
// Shared types for the Intra_net tile address sequencer: FSM states, tile coordinates
// and the row-major coordinate step used by both the read and write sides.
package intra_net_pkg;

  localparam int IDX_W       = 4;
  localparam int MAX_LAT_DEF = 16;
  localparam int LAT_W       = $clog2(MAX_LAT_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] r;
    logic [IDX_W-1:0] c;
  } tile_coord_t;

  function automatic tile_coord_t coord_step(input tile_coord_t p, input logic [IDX_W-1:0] cols_m1);
    tile_coord_t n;
    if (p.c == cols_m1) begin
      n.r = p.r + 1'b1;
      n.c = '0;
    end else begin
      n.r = p.r;
      n.c = p.c + 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/intra_net_delay_line.sv
// Shift register carrying {valid, last} from the read strobe to the write strobe,
// with a runtime tap so the write side sees the read stream cfg_lat advancing cycles later.
module intra_net_delay_line #(
  parameter int MAX_LAT = 16,
  parameter int LW      = $clog2(MAX_LAT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          shift,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [LW-1:0] lat,
  output logic          out_valid,
  output logic          out_last
);

  logic [MAX_LAT-1:0] v_q;
  logic [MAX_LAT-1:0] l_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      v_q <= '0;
      l_q <= '0;
    end else if (shift) begin
      v_q[0] <= in_valid;
      l_q[0] <= in_last;
      for (int i = 1; i < MAX_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  // Latencies beyond the line depth saturate at the deepest stage.
  always_comb begin
    out_valid = v_q[MAX_LAT-1];
    out_last  = l_q[MAX_LAT-1];
    if (lat == '0) begin
      out_valid = in_valid;
      out_last  = in_last;
    end else begin
      for (int i = 1; i < MAX_LAT; i++) begin
        if (lat == LW'(i)) begin
          out_valid = v_q[i-1];
          out_last  = l_q[i-1];
        end
      end
    end
  end

endmodule

// File: rtl/intra_net_tile_addr_gen.sv
// Tile address sequencer: linear output-buffer reads, row-strided activation-buffer writes
// delayed by the cast-pipeline latency, with a done pulse after the last write.
module intra_net_tile_addr_gen
  import intra_net_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int IDX_WIDTH  = IDX_W,
  parameter int MAX_LAT    = MAX_LAT_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             hold,
  input  logic [ADDR_WIDTH-1:0]            O_base_addr,
  input  logic [ADDR_WIDTH-1:0]            A_base_addr,
  input  logic [ADDR_WIDTH-1:0]            A_stride,
  input  logic [IDX_WIDTH-1:0]             cfg_rows_m1,
  input  logic [IDX_WIDTH-1:0]             cfg_cols_m1,
  input  logic [$clog2(MAX_LAT+1)-1:0]     cfg_lat,
  output logic                             O_rd_en,
  output logic [ADDR_WIDTH-1:0]            O_addr,
  output logic                             A_w_en,
  output logic [ADDR_WIDTH-1:0]            A_addr,
  output logic                             busy,
  output logic                             done
);

  localparam int LW = $clog2(MAX_LAT + 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] o_addr_q, a_addr_q, a_row_q, stride_q;
  logic [IDX_WIDTH-1:0]  rows_m1_q, cols_m1_q;
  logic [LW-1:0]         lat_q;
  tile_coord_t           o_pos_q, a_pos_q;
  logic                  rd_q;
  logic                  accept, o_last, o_issue, a_issue, tap_valid, tap_last;

  assign accept  = (state_q == IDLE) && start && !hold;
  assign o_last  = (o_pos_q.r == rows_m1_q) && (o_pos_q.c == cols_m1_q);
  assign o_issue = rd_q && !hold;
  assign a_issue = tap_valid && !hold;

  intra_net_delay_line #(.MAX_LAT(MAX_LAT), .LW(LW)) u_delay (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .shift     (!hold),
    .in_valid  (rd_q),
    .in_last   (o_last),
    .lat       (lat_q),
    .out_valid (tap_valid),
    .out_last  (tap_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // With zero latency the final read and final write land in the same cycle.
  always_comb begin
    state_d = state_q;
    if (!hold) begin
      case (state_q)
        IDLE:    if (start) state_d = READ;
        READ:    if (o_issue && o_last) state_d = (a_issue && tap_last) ? DONE : DRAIN;
        DRAIN:   if (a_issue && tap_last) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_addr_q  <= '0;
      a_addr_q  <= '0;
      a_row_q   <= '0;
      stride_q  <= '0;
      rows_m1_q <= '0;
      cols_m1_q <= '0;
      lat_q     <= '0;
      o_pos_q   <= '0;
      a_pos_q   <= '0;
      rd_q      <= 1'b0;
    end else if (!hold) begin
      if (accept) begin
        o_addr_q  <= O_base_addr;
        a_addr_q  <= A_base_addr;
        a_row_q   <= A_base_addr;
        stride_q  <= A_stride;
        rows_m1_q <= cfg_rows_m1;
        cols_m1_q <= cfg_cols_m1;
        lat_q     <= cfg_lat;
        o_pos_q   <= '0;
        a_pos_q   <= '0;
        rd_q      <= 1'b1;
      end else begin
        if (rd_q) begin
          if (o_last) begin
            rd_q <= 1'b0;
          end else begin
            o_addr_q <= o_addr_q + 1'b1;
            o_pos_q  <= coord_step(o_pos_q, cols_m1_q);
          end
        end
        // The final write leaves the address in place rather than stepping past the tile.
        if (tap_valid && !tap_last) begin
          if (a_pos_q.c == cols_m1_q) begin
            a_row_q  <= a_row_q + stride_q;
            a_addr_q <= a_row_q + stride_q;
          end else begin
            a_addr_q <= a_addr_q + 1'b1;
          end
          a_pos_q <= coord_step(a_pos_q, cols_m1_q);
        end
      end
    end
  end

  assign O_rd_en = o_issue;
  assign O_addr  = o_addr_q;
  assign A_w_en  = a_issue;
  assign A_addr  = a_addr_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE) && !hold;

endmodule

// File: tb/tb_intra_net_tile_addr_gen.sv
// Directed bench for intra_net_tile_addr_gen: strobes are logged with their cycle number
// and each scenario task compares the log against hand-derived address/cycle sequences.
module tb_intra_net_tile_addr_gen;

  logic       clk = 1'b0;
  logic       reset, start, hold;
  logic [9:0] O_base_addr, A_base_addr, A_stride;
  logic [3:0] cfg_rows_m1, cfg_cols_m1;
  logic [4:0] cfg_lat;
  logic       O_rd_en, A_w_en, busy, done;
  logic [9:0] O_addr, A_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_a[$], rd_c[$], wr_a[$], wr_c[$], dn_c[$];

  intra_net_tile_addr_gen dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .O_base_addr(O_base_addr), .A_base_addr(A_base_addr), .A_stride(A_stride),
    .cfg_rows_m1(cfg_rows_m1), .cfg_cols_m1(cfg_cols_m1), .cfg_lat(cfg_lat),
    .O_rd_en(O_rd_en), .O_addr(O_addr), .A_w_en(A_w_en), .A_addr(A_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (O_rd_en) begin rd_a.push_back(int'(O_addr)); rd_c.push_back(cyc); end
    if (A_w_en)  begin wr_a.push_back(int'(A_addr)); wr_c.push_back(cyc); end
    if (done)    dn_c.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    rd_a.delete(); rd_c.delete(); wr_a.delete(); wr_c.delete(); dn_c.delete();
  endtask

  task automatic launch(input logic [9:0] ob, input logic [9:0] ab, input logic [9:0] st,
                        input logic [3:0] rm, input logic [3:0] cm, input logic [4:0] lat,
                        output int t0);
    @(posedge clk); #1;
    O_base_addr = ob; A_base_addr = ab; A_stride = st;
    cfg_rows_m1 = rm; cfg_cols_m1 = cm; cfg_lat = lat;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (dn_c.size() == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; hold = 1'b0;
    O_base_addr = '0; A_base_addr = '0; A_stride = '0;
    cfg_rows_m1 = '0; cfg_cols_m1 = '0; cfg_lat = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({O_rd_en, A_w_en, busy, done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {O_rd_en, A_w_en, busy, done});
    end
    n_checks++;
    if ({O_addr, A_addr} !== 20'h0) begin
      n_fail++; $display("FAIL reset_addr: got O=%h A=%h want 0", O_addr, A_addr);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_base();
    int t0;
    clear_logs();
    launch(10'h010, 10'h100, 10'd4, 4'd3, 4'd3, 5'd3, t0);
    wait_done(100);
    n_checks++;
    if (rd_a.size() != 16 || wr_a.size() != 16) begin
      n_fail++; $display("FAIL base_count: got rd=%0d wr=%0d want 16/16", rd_a.size(), wr_a.size());
    end
    for (int k = 0; k < 16 && k < rd_a.size(); k++) begin
      n_checks++;
      if (rd_a[k] != 'h010 + k || rd_c[k] != t0 + 1 + k) begin
        n_fail++; $display("FAIL base_rd[%0d]: got %h@%0d want %h@%0d", k, rd_a[k], rd_c[k] - t0, 'h010 + k, 1 + k);
      end
    end
    for (int k = 0; k < 16 && k < wr_a.size(); k++) begin
      n_checks++;
      if (wr_a[k] != 'h100 + k || wr_c[k] != t0 + 4 + k) begin
        n_fail++; $display("FAIL base_wr[%0d]: got %h@%0d want %h@%0d", k, wr_a[k], wr_c[k] - t0, 'h100 + k, 4 + k);
      end
    end
    n_checks++;
    if (dn_c.size() != 1 || (dn_c.size() > 0 && dn_c[0] != t0 + 20)) begin
      n_fail++; $display("FAIL base_done: got count=%0d want one pulse at T+20", dn_c.size());
    end
  endtask

  task automatic test_strided();
    int t0;
    int ea[6] = '{'h100, 'h101, 'h102, 'h108, 'h109, 'h10A};
    clear_logs();
    launch(10'h010, 10'h100, 10'd8, 4'd1, 4'd2, 5'd0, t0);
    wait_done(50);
    n_checks++;
    if (rd_a.size() != 6 || wr_a.size() != 6) begin
      n_fail++; $display("FAIL strided_count: got rd=%0d wr=%0d want 6/6", rd_a.size(), wr_a.size());
    end
    for (int k = 0; k < 6 && k < wr_a.size() && k < rd_a.size(); k++) begin
      n_checks++;
      if (wr_a[k] != ea[k] || wr_c[k] != t0 + 1 + k || rd_c[k] != t0 + 1 + k || rd_a[k] != 'h010 + k) begin
        n_fail++; $display("FAIL strided[%0d]: got wr %h@%0d rd %h@%0d want wr %h@%0d", k, wr_a[k], wr_c[k] - t0, rd_a[k], rd_c[k] - t0, ea[k], 1 + k);
      end
    end
    n_checks++;
    if (dn_c.size() != 1 || (dn_c.size() > 0 && dn_c[0] != t0 + 7)) begin
      n_fail++; $display("FAIL strided_done: got count=%0d want one pulse at T+7", dn_c.size());
    end
  endtask

  task automatic test_wrap();
    int t0;
    clear_logs();
    launch(10'h3FE, 10'h3FF, 10'd4, 4'd0, 4'd3, 5'd1, t0);
    wait_done(50);
    n_checks++;
    if (rd_a.size() != 4 || wr_a.size() != 4) begin
      n_fail++; $display("FAIL wrap_count: got rd=%0d wr=%0d want 4/4", rd_a.size(), wr_a.size());
    end
    for (int k = 0; k < 4 && k < rd_a.size() && k < wr_a.size(); k++) begin
      n_checks++;
      if (rd_a[k] != ('h3FE + k) % 1024 || wr_a[k] != ('h3FF + k) % 1024 || wr_c[k] != t0 + 2 + k) begin
        n_fail++; $display("FAIL wrap[%0d]: got rd %h wr %h@%0d want rd %h wr %h@%0d", k, rd_a[k], wr_a[k], wr_c[k] - t0, ('h3FE + k) % 1024, ('h3FF + k) % 1024, 2 + k);
      end
    end
    n_checks++;
    if (dn_c.size() != 1 || (dn_c.size() > 0 && dn_c[0] != t0 + 6)) begin
      n_fail++; $display("FAIL wrap_done: got count=%0d want one pulse at T+6", dn_c.size());
    end
  endtask

  // Non-hold cycle n (1-based after start) maps to T+n, shifted by 3 once the hold window passes.
  function automatic int nh_cyc(input int t0, input int n);
    return (n <= 5) ? t0 + n : t0 + n + 3;
  endfunction

  task automatic test_hold();
    int t0;
    clear_logs();
    launch(10'h010, 10'h100, 10'd4, 4'd3, 4'd3, 5'd2, t0);
    repeat (5) @(posedge clk);
    #1;
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      #3;
      n_checks++;
      if (O_rd_en !== 1'b0 || A_w_en !== 1'b0 || O_addr !== 10'h015 || A_addr !== 10'h103) begin
        n_fail++; $display("FAIL hold_freeze[%0d]: got rd=%b wr=%b O=%h A=%h want 0 0 015 103", h, O_rd_en, A_w_en, O_addr, A_addr);
      end
      @(posedge clk); #1;
    end
    hold = 1'b0;
    wait_done(100);
    n_checks++;
    if (rd_a.size() != 16 || wr_a.size() != 16) begin
      n_fail++; $display("FAIL hold_count: got rd=%0d wr=%0d want 16/16", rd_a.size(), wr_a.size());
    end
    for (int k = 0; k < 16 && k < rd_a.size() && k < wr_a.size(); k++) begin
      n_checks++;
      if (rd_a[k] != 'h010 + k || rd_c[k] != nh_cyc(t0, k + 1) || wr_a[k] != 'h100 + k || wr_c[k] != nh_cyc(t0, k + 3)) begin
        n_fail++; $display("FAIL hold_seq[%0d]: got rd %h@%0d wr %h@%0d want rd %h@%0d wr %h@%0d", k, rd_a[k], rd_c[k] - t0, wr_a[k], wr_c[k] - t0, 'h010 + k, nh_cyc(0, k + 1), 'h100 + k, nh_cyc(0, k + 3));
      end
    end
    n_checks++;
    if (dn_c.size() != 1 || (dn_c.size() > 0 && dn_c[0] != t0 + 22)) begin
      n_fail++; $display("FAIL hold_done: got count=%0d want one pulse at T+22", dn_c.size());
    end
  endtask

  task automatic test_control();
    int t0;
    clear_logs();
    launch(10'h010, 10'h100, 10'd4, 4'd3, 4'd3, 5'd1, t0);
    @(posedge clk); #1;
    O_base_addr = 10'h200; cfg_rows_m1 = 4'd0; cfg_lat = 5'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    n_checks++;
    if (rd_a.size() != 16 || wr_a.size() != 16 || dn_c.size() != 1) begin
      n_fail++; $display("FAIL ignore_count: got rd=%0d wr=%0d done=%0d want 16/16/1", rd_a.size(), wr_a.size(), dn_c.size());
    end
    for (int k = 0; k < 16 && k < rd_a.size() && k < wr_a.size(); k++) begin
      n_checks++;
      if (rd_a[k] != 'h010 + k || wr_a[k] != 'h100 + k || wr_c[k] != t0 + 2 + k) begin
        n_fail++; $display("FAIL ignore_seq[%0d]: got rd %h wr %h@%0d want rd %h wr %h@%0d", k, rd_a[k], wr_a[k], wr_c[k] - t0, 'h010 + k, 'h100 + k, 2 + k);
      end
    end
    n_checks++;
    if (dn_c.size() > 0 && dn_c[0] != t0 + 18) begin
      n_fail++; $display("FAIL ignore_done: got T+%0d want T+18", dn_c[0] - t0);
    end

    clear_logs();
    launch(10'h010, 10'h100, 10'd4, 4'd3, 4'd3, 5'd3, t0);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({O_rd_en, A_w_en, busy, done} !== 4'b0000 || {O_addr, A_addr} !== 20'h0) begin
      n_fail++; $display("FAIL abort_outputs: got ctrl=%b O=%h A=%h want all 0", {O_rd_en, A_w_en, busy, done}, O_addr, A_addr);
    end
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if (rd_a.size() != 7 || wr_a.size() != 4 || dn_c.size() != 0) begin
      n_fail++; $display("FAIL abort_counts: got rd=%0d wr=%0d done=%0d want 7/4/0", rd_a.size(), wr_a.size(), dn_c.size());
    end
  endtask

  task automatic test_extremes();
    int t0;
    int bad;
    clear_logs();
    launch(10'h000, 10'h100, 10'd16, 4'd15, 4'd15, 5'd16, t0);
    wait_done(400);
    n_checks++;
    if (rd_a.size() != 256 || wr_a.size() != 256 || dn_c.size() != 1) begin
      n_fail++; $display("FAIL max_count: got rd=%0d wr=%0d done=%0d want 256/256/1", rd_a.size(), wr_a.size(), dn_c.size());
    end
    bad = 0;
    for (int k = 0; k < 256 && k < rd_a.size() && k < wr_a.size(); k++)
      if (rd_a[k] != k || wr_a[k] != 'h100 + k || wr_c[k] != t0 + 17 + k) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL max_seq: got %0d wrong entries want 0", bad);
    end
    n_checks++;
    if (dn_c.size() > 0 && dn_c[0] != t0 + 273) begin
      n_fail++; $display("FAIL max_done: got T+%0d want T+273", dn_c[0] - t0);
    end

    clear_logs();
    launch(10'h055, 10'h2AA, 10'd1, 4'd0, 4'd0, 5'd0, t0);
    wait_done(20);
    n_checks++;
    if (rd_a.size() != 1 || wr_a.size() != 1 || dn_c.size() != 1) begin
      n_fail++; $display("FAIL one_count: got rd=%0d wr=%0d done=%0d want 1/1/1", rd_a.size(), wr_a.size(), dn_c.size());
    end else begin
      n_checks++;
      if (rd_a[0] != 'h055 || rd_c[0] != t0 + 1 || wr_a[0] != 'h2AA || wr_c[0] != t0 + 1 || dn_c[0] != t0 + 2) begin
        n_fail++; $display("FAIL one_seq: got rd %h@%0d wr %h@%0d done@%0d want 055@1 2AA@1 done@2", rd_a[0], rd_c[0] - t0, wr_a[0], wr_c[0] - t0, dn_c[0] - t0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_strided();
    test_wrap();
    test_hold();
    test_control();
    test_extremes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
